// File: rtl/pad_cfg_sequencer.sv
// Pad configuration array with glitch-safe single-pad updates: the target pad's
// OE is masked for a guard window before and after its configuration changes.
module pad_cfg_sequencer #(
    parameter int              N_PADS       = 48,
    parameter int              CFG_W        = 6,
    parameter int              GUARD_CYCLES = 4,
    parameter logic [CFG_W-1:0] RESET_CFG   = '0,
    localparam int             IDX_W        = $clog2(N_PADS)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [IDX_W-1:0]                 req_idx_i,
    input  logic [CFG_W-1:0]                 req_cfg_i,
    input  logic [IDX_W-1:0]                 rd_idx_i,
    output logic [CFG_W-1:0]                 rd_cfg_o,
    output logic [N_PADS-1:0][CFG_W-1:0]     pad_cfg_o,
    output logic [N_PADS-1:0]                oe_mask_o,
    output logic                             busy_o,
    output logic                             err_o
);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15) begin : g_bad_guard
        $error("pad_cfg_sequencer: GUARD_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        APPLY = 2'd2,
        POST  = 2'd3
    } state_t;

    localparam logic [IDX_W:0] N_PADS_W = (IDX_W + 1)'(N_PADS);
    localparam logic [3:0]     PRE_LD   = 4'(GUARD_CYCLES - 1);
    // The post window starts one cycle later than the pre window ends, so the
    // mask stays up for the full guard after the new value is on the pads.
    localparam logic [3:0]     POST_LD  = 4'(GUARD_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [CFG_W-1:0]      cfg_q;
    logic [N_PADS-1:0]     mask_q, mask_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  apply;
    logic                  req_in_range;

    assign req_in_range = {1'b0, req_idx_i} < N_PADS_W;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        err_d       = 1'b0;
        accept      = 1'b0;
        apply       = 1'b0;
        req_ready_o = (state_q == IDLE);
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (req_in_range) begin
                        state_d           = PRE;
                        cnt_d             = PRE_LD;
                        mask_d            = '0;
                        mask_d[req_idx_i] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                if (cnt_q == 4'd0) state_d = APPLY;
                else               cnt_d   = cnt_q - 4'd1;
            end
            APPLY: begin
                apply   = 1'b1;
                cnt_d   = POST_LD;
                state_d = POST;
            end
            POST: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    mask_d  = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the pad array is reset along with the control state; the pad frame
    // must see a defined configuration the moment reset asserts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            cfg_q     <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            pad_cfg_o <= {N_PADS{RESET_CFG}};
        end else begin
            // NOTE: non-blocking assignments keep every register update based on
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            if (accept) begin
                idx_q <= req_idx_i;
                cfg_q <= req_cfg_i;
            end
            if (apply) pad_cfg_o[idx_q] <= cfg_q;
        end
    end

    assign oe_mask_o = mask_q;
    assign busy_o    = (state_q != IDLE);
    assign err_o     = err_q;
    assign rd_cfg_o  = ({1'b0, rd_idx_i} < N_PADS_W) ? pad_cfg_o[rd_idx_i] : '0;

    a_mask_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(oe_mask_o));

    for (genvar p = 0; p < N_PADS; p++) begin : g_chk
        a_change_masked : assert property (@(posedge clk_i) disable iff (!rst_ni)
            $changed(pad_cfg_o[p]) |-> oe_mask_o[p]);
    end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer: inputs driven and outputs sampled on the
// falling edge; expected values are hand-derived cycle by cycle.
module tb_pad_cfg_sequencer;

    localparam int N_PADS = 48;
    localparam int CFG_W  = 6;
    localparam int IDX_W  = 6;

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b0;
    logic                         req_valid_i = 1'b0;
    logic                         req_ready_o;
    logic [IDX_W-1:0]             req_idx_i = '0;
    logic [CFG_W-1:0]             req_cfg_i = '0;
    logic [IDX_W-1:0]             rd_idx_i = '0;
    logic [CFG_W-1:0]             rd_cfg_o;
    logic [N_PADS-1:0][CFG_W-1:0] pad_cfg_o;
    logic [N_PADS-1:0]            oe_mask_o;
    logic                         busy_o;
    logic                         err_o;

    logic [N_PADS-1:0][CFG_W-1:0] exp_cfg = '0;
    int n_tests = 0;
    int n_fail  = 0;

    pad_cfg_sequencer #(
        .N_PADS(48), .CFG_W(6), .GUARD_CYCLES(4), .RESET_CFG(6'h00)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_idx_i(req_idx_i), .req_cfg_i(req_cfg_i),
        .rd_idx_i(rd_idx_i), .rd_cfg_o(rd_cfg_o),
        .pad_cfg_o(pad_cfg_o), .oe_mask_o(oe_mask_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [N_PADS-1:0] bit_of(input int i);
        logic [N_PADS-1:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        n_tests++;
        if (pad_cfg_o !== exp_cfg) begin
            n_fail++; $display("FAIL reset_cfg got=%h exp=%h", pad_cfg_o, exp_cfg);
        end
        n_tests++;
        if (oe_mask_o !== '0) begin
            n_fail++; $display("FAIL reset_mask got=%h exp=0", oe_mask_o);
        end
        n_tests++;
        if ({req_ready_o, busy_o, err_o} !== 3'b100) begin
            n_fail++; $display("FAIL reset_ctrl got rdy/busy/err=%b exp=100",
                               {req_ready_o, busy_o, err_o});
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single_write();
        logic [N_PADS-1:0] m_exp;
        logic [CFG_W-1:0]  c_exp;
        rd_idx_i    = 6'd7;
        req_valid_i = 1'b1;
        req_idx_i   = 6'd7;
        req_cfg_i   = 6'h01;
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL sw_ready_c0 got=%b exp=1", req_ready_o);
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            m_exp = (c >= 1 && c <= 10) ? bit_of(7) : '0;
            c_exp = (c >= 6) ? 6'h01 : 6'h00;
            n_tests++;
            if (oe_mask_o !== m_exp) begin
                n_fail++; $display("FAIL sw_mask c%0d got=%h exp=%h", c, oe_mask_o, m_exp);
            end
            n_tests++;
            if (pad_cfg_o[7] !== c_exp) begin
                n_fail++; $display("FAIL sw_pad7 c%0d got=%h exp=%h", c, pad_cfg_o[7], c_exp);
            end
            n_tests++;
            if (rd_cfg_o !== c_exp) begin
                n_fail++; $display("FAIL sw_rd7 c%0d got=%h exp=%h", c, rd_cfg_o, c_exp);
            end
            n_tests++;
            if (req_ready_o !== (c >= 11) || busy_o !== (c <= 10)) begin
                n_fail++; $display("FAIL sw_ready_busy c%0d got=%b%b exp=%b%b", c,
                                   req_ready_o, busy_o, c >= 11, c <= 10);
            end
        end
        exp_cfg[7] = 6'h01;
        n_tests++;
        if (pad_cfg_o !== exp_cfg) begin
            n_fail++; $display("FAIL sw_array got=%h exp=%h", pad_cfg_o, exp_cfg);
        end
    endtask

    task automatic test_back_to_back();
        logic [N_PADS-1:0] m_exp;
        req_valid_i = 1'b1;
        req_idx_i   = 6'd0;
        req_cfg_i   = 6'h2A;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                req_idx_i = 6'd47;
                req_cfg_i = 6'h15;
            end
            if (c == 12) req_valid_i = 1'b0;
            m_exp = (c <= 10) ? bit_of(0) : (c >= 12 && c <= 21) ? bit_of(47) : '0;
            n_tests++;
            if (oe_mask_o !== m_exp) begin
                n_fail++; $display("FAIL b2b_mask c%0d got=%h exp=%h", c, oe_mask_o, m_exp);
            end
            n_tests++;
            if (req_ready_o !== (c == 11 || c == 22)) begin
                n_fail++; $display("FAIL b2b_ready c%0d got=%b exp=%b", c, req_ready_o,
                                   c == 11 || c == 22);
            end
            n_tests++;
            if (pad_cfg_o[0] !== ((c >= 6) ? 6'h2A : 6'h00)) begin
                n_fail++; $display("FAIL b2b_pad0 c%0d got=%h", c, pad_cfg_o[0]);
            end
            n_tests++;
            if (pad_cfg_o[47] !== ((c >= 17) ? 6'h15 : 6'h00)) begin
                n_fail++; $display("FAIL b2b_pad47 c%0d got=%h", c, pad_cfg_o[47]);
            end
        end
        exp_cfg[0]  = 6'h2A;
        exp_cfg[47] = 6'h15;
        n_tests++;
        if (pad_cfg_o !== exp_cfg) begin
            n_fail++; $display("FAIL b2b_array got=%h exp=%h", pad_cfg_o, exp_cfg);
        end
    endtask

    task automatic test_out_of_range();
        logic [IDX_W-1:0] bad [3] = '{6'd48, 6'd50, 6'd63};
        foreach (bad[k]) begin
            req_valid_i = 1'b1;
            req_idx_i   = bad[k];
            req_cfg_i   = 6'h3F;
            n_tests++;
            if (req_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL oor_ready idx=%0d got=%b exp=1", bad[k], req_ready_o);
            end
            @(negedge clk_i);
            req_valid_i = 1'b0;
            n_tests++;
            if ({err_o, busy_o, req_ready_o} !== 3'b101 || oe_mask_o !== '0) begin
                n_fail++; $display("FAIL oor_pulse idx=%0d got err/busy/rdy=%b mask=%h exp=101/0",
                                   bad[k], {err_o, busy_o, req_ready_o}, oe_mask_o);
            end
            @(negedge clk_i);
            n_tests++;
            if (err_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL oor_clear idx=%0d got err/busy=%b%b exp=00",
                                   bad[k], err_o, busy_o);
            end
            n_tests++;
            if (pad_cfg_o !== exp_cfg) begin
                n_fail++; $display("FAIL oor_array idx=%0d got=%h exp=%h", bad[k], pad_cfg_o, exp_cfg);
            end
        end
    endtask

    task automatic test_readback();
        logic [IDX_W-1:0] idx [4] = '{6'd0, 6'd47, 6'd60, 6'd48};
        logic [CFG_W-1:0] exp [4] = '{6'h2A, 6'h15, 6'h00, 6'h00};
        foreach (idx[k]) begin
            rd_idx_i = idx[k];
            #1;
            n_tests++;
            if (rd_cfg_o !== exp[k]) begin
                n_fail++; $display("FAIL rd idx=%0d got=%h exp=%h", idx[k], rd_cfg_o, exp[k]);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_post();
        int k;
        req_valid_i = 1'b1;
        req_idx_i   = 6'd3;
        req_cfg_i   = 6'h3C;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
        end
        n_tests++;
        if (pad_cfg_o[3] !== 6'h3C || oe_mask_o !== bit_of(3)) begin
            n_fail++; $display("FAIL rp_post got pad3=%h mask=%h exp=3c/%h",
                               pad_cfg_o[3], oe_mask_o, bit_of(3));
        end
        rst_ni = 1'b0;
        #1;
        exp_cfg = '0;
        n_tests++;
        if (oe_mask_o !== '0 || pad_cfg_o !== exp_cfg) begin
            n_fail++; $display("FAIL rp_async got mask=%h cfg=%h exp=0", oe_mask_o, pad_cfg_o);
        end
        n_tests++;
        if ({req_ready_o, busy_o, err_o} !== 3'b100) begin
            n_fail++; $display("FAIL rp_ctrl got=%b exp=100", {req_ready_o, busy_o, err_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_idx_i   = 6'd5;
        req_cfg_i   = 6'h07;
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rp_first_ready got=%b exp=1", req_ready_o);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b1 || oe_mask_o !== bit_of(5)) begin
            n_fail++; $display("FAIL rp_accept got busy=%b mask=%h exp=1/%h",
                               busy_o, oe_mask_o, bit_of(5));
        end
        k = 1;
        while (!req_ready_o && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        n_tests++;
        if (k !== 11) begin
            n_fail++; $display("FAIL rp_ready_return got cycle=%0d exp=11", k);
        end
        exp_cfg[5] = 6'h07;
        n_tests++;
        if (pad_cfg_o !== exp_cfg) begin
            n_fail++; $display("FAIL rp_array got=%h exp=%h", pad_cfg_o, exp_cfg);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_out_of_range();
        test_readback();
        test_reset_post();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
